// File: rtl/popcount_stream_accum.sv
// popcount_stream_accum: sums per-byte popcounts over a frame, counts beats,
// flags saturation and oversized counts, and holds the result until taken.
//
// state | meaning
// IDLE  | no beat accepted yet for the current frame
// ACCUM | frame in progress
// DONE  | result held on the output until out_ready
module popcount_stream_accum #(
  parameter int SUM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_count,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             in_abort,
  output logic [SUM_W-1:0] out_sum,
  output logic [15:0]      out_beats,
  output logic             out_ovf,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  logic [1:0]       r_state;
  logic [SUM_W-1:0] r_sum;
  logic [15:0]      r_beats;
  logic             r_ovf;
  logic             r_err;
  logic             r_rdy_en;

  logic             w_accept;
  logic             w_big;
  logic [3:0]       w_clamped;
  logic [SUM_W:0]   w_sum_ext;
  logic [SUM_W-1:0] w_sum_sat;
  logic [15:0]      w_beats_next;

  // r_rdy_en keeps in_ready low until the first clock edge after reset release
  assign in_ready  = r_rdy_en && (r_state != DONE) && !in_abort;
  assign w_accept  = in_valid && in_ready;
  assign w_big     = (in_count > 4'd8);
  assign w_clamped = w_big ? 4'd8 : in_count;
  assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W-3){1'b0}}, w_clamped};
  assign w_sum_sat = w_sum_ext[SUM_W] ? SUM_MAX : w_sum_ext[SUM_W-1:0];
  assign w_beats_next = (r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1;

  assign out_valid = (r_state == DONE);
  assign out_sum   = out_valid ? r_sum   : '0;
  assign out_beats = out_valid ? r_beats : 16'd0;
  assign out_ovf   = out_valid && r_ovf;
  assign out_err   = out_valid && r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sum    <= '0;
      r_beats  <= 16'd0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_state)
        IDLE, ACCUM: begin
          if (in_abort) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_beats <= 16'd0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_accept) begin
            r_sum   <= w_sum_sat;
            r_beats <= w_beats_next;
            r_ovf   <= r_ovf | w_sum_ext[SUM_W];
            r_err   <= r_err | w_big;
            r_state <= in_last ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_beats <= 16'd0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/popcount_stream_accum.md
POPCOUNT_STREAM_ACCUM -- requirements
Module: popcount_stream_accum

Interface
REQ-001 The block SHALL have one parameter: SUM_W, default 16, width of the frame sum (legal range 4..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_count  input  4  per-byte popcount from the upstream 8-bit popcount stage (legal 0..8).
REQ-005 Port: in_valid  input  1  in_count/in_last valid this cycle.
REQ-006 Port: in_last  input  1  marks the final beat of a frame.
REQ-007 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-008 Port: in_abort  input  1  synchronous drop of the partial frame.
REQ-009 Port: out_sum  output  SUM_W  total set bits in the completed frame.
REQ-010 Port: out_beats  output  16  number of beats accepted in the frame.
REQ-011 Port: out_ovf  output  1  frame sum saturated.
REQ-012 Port: out_err  output  1  at least one beat carried in_count > 8.
REQ-013 Port: out_valid  output  1  frame result valid.
REQ-014 Port: out_ready  input  1  downstream accepts the result.

Function
REQ-015 States SHALL be IDLE (no beat accepted yet), ACCUM (frame in progress) and DONE (result held).
REQ-016 in_ready SHALL be 1 in IDLE or ACCUM with in_abort=0, and 0 in DONE or when in_abort=1.
REQ-017 A beat is accepted when in_valid and in_ready are both 1; no other cycle SHALL change the accumulators.
REQ-018 An accepted in_count > 8 SHALL be clamped to 8 before addition and SHALL set the frame's err flag.
REQ-019 sum_next = sum + clamped count; if the result exceeds 2^SUM_W-1, sum SHALL hold 2^SUM_W-1 and the ovf flag SHALL set (sticky for the frame).
REQ-020 The beat counter SHALL increment per accepted beat and saturate at 65535 without wrapping.
REQ-021 Transitions: IDLE->ACCUM on accepted non-last beat; IDLE->DONE on accepted last beat (single-beat frame); ACCUM->DONE on accepted last beat; DONE->IDLE on out_valid and out_ready; IDLE/ACCUM->IDLE on in_abort.
REQ-022 out_valid SHALL rise in the cycle after the last beat is accepted (latency 1) and hold with out_sum/out_beats/out_ovf/out_err stable until out_ready=1.
REQ-023 On the result handshake, sum, beat counter, ovf and err SHALL clear; in_ready SHALL be 1 in the following cycle (one-cycle bubble between frames).
REQ-024 in_abort in IDLE/ACCUM SHALL clear all accumulators and return to IDLE in the next cycle; a beat presented in the same cycle SHALL be dropped (not accepted).
REQ-025 in_abort in DONE SHALL be ignored; the held result is unaffected.
REQ-026 out_sum, out_beats, out_ovf, out_err SHALL be driven 0 whenever out_valid=0.
REQ-027 in_last with in_count=0 SHALL complete the frame normally (sum unchanged, beats incremented).

Reset
REQ-028 While rst_n=0 the block SHALL be in IDLE with all accumulators 0, out_valid=0, all result outputs 0, and in_ready=0.
REQ-029 in_ready SHALL become 1 in the first clock cycle after rst_n deasserts; a partial or held frame at reset assertion SHALL be discarded.

Verification
REQ-030 Beats 3,5,8,0(last), out_ready=1 -> one cycle after last: out_valid=1, out_sum=16, out_beats=4, ovf=0, err=0; in_ready=1 two cycles after last.
REQ-031 SUM_W=4, beats 8,8(last) -> out_sum=15, out_ovf=1, out_beats=2.
REQ-032 Beats 12,1(last) -> out_sum=9, out_err=1.
REQ-033 Single beat 7 with in_last, out_ready=0 for 5 cycles -> out_valid and out_sum=7 stable 5 cycles, in_ready=0 throughout; clears after out_ready=1.
REQ-034 Beats 4,4, then in_abort with in_valid=1 count 6, then 2(last) -> out_sum=2, out_beats=1.
REQ-035 rst_n pulsed low after 2 beats of a frame -> outputs 0 immediately; next frame 1(last) -> out_sum=1, out_beats=1.
